// File: rtl/sipo_pkg.sv
// Shared state type, sizing constants and the parity helper for the sipo_deser receiver.
// The parity helper is only referenced when SIPO_PARITY_EN is defined.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } sipo_state_e;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH + 1);
  localparam int unsigned PAR_MAX_W = 64;

  // Parity bit the transmitter must append so that data plus parity has the requested sense.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial line plus parallel valid/ready bus of the sipo_deser receiver.
// master = the deserializer, slave = the serial source / word consumer side.
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             sl;
  logic             sin;
  logic             pout_ready;
  logic             pout_valid;
  logic [WIDTH-1:0] pout;

  modport master (input sl, sin, pout_ready, output pout, pout_valid);
  modport slave  (output sl, sin, pout_ready, input pout, pout_valid);

endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register with sticky overrun detection.
// Carries a per-word error flag alongside the data when SIPO_PARITY_EN is defined.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             clr_i,
`ifdef SIPO_PARITY_EN
  input  logic             err_i,
  output logic             err_o,
`endif
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             handshake;
  logic             accept;

`ifdef SIPO_PARITY_EN
  logic             err_q;
`endif

  assign handshake = valid_q && ready_i;
  assign accept    = load_i && (!valid_q || ready_i);

  // A new word may replace the held one only when the consumer takes it on the same edge;
  // otherwise the new word is lost and the overrun set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
        err_q   <= err_i;
`endif
      end else if (handshake) begin
        valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
        err_q   <= 1'b0;
`endif
      end

      if (load_i && !accept) begin
        overrun_q <= 1'b1;
      end else if (clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
`ifdef SIPO_PARITY_EN
  assign err_o     = err_q;
`endif

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out receiver for the PISO link: frame FSM, shift register and bit counter.
// Defining SIPO_PARITY_EN appends one checked parity bit to every frame.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sipo_deser_if.master               bus,
  input  logic                       overrun_clr,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int unsigned     CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastData = CntW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > PAR_MAX_W || PARITY_ODD > 1) begin : g_bad_param
    $error("sipo_deser: WIDTH must be 2..64 and PARITY_ODD 0 or 1");
  end

  sipo_state_e      state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  bitCnt_q;
  logic [WIDTH-1:0] shift_d;
  logic             wordDone;
  logic [WIDTH-1:0] word;

  always_comb begin
    if (MSB_FIRST != 0) begin
      shift_d = {shift_q[WIDTH-2:0], bus.sin};
    end else begin
      shift_d = {bus.sin, shift_q[WIDTH-1:1]};
    end
  end

`ifdef SIPO_PARITY_EN
  logic wordErr;

  // The data is already complete in the shift register; the parity edge only adds the check bit.
  assign wordDone = bus.sl && (state_q == PARITY);
  assign word     = shift_q;
  assign wordErr  = bus.sin != calc_parity(PAR_MAX_W'(shift_q), PARITY_ODD != 0);
`else
  assign wordDone = bus.sl && (state_q == SHIFT) && (bitCnt_q == LastData);
  assign word     = shift_d;
`endif

  // A low sl between bits discards the partial frame; after a completed frame the FSM parks
  // in SHIFT with a zero count so a back-to-back frame needs no gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
    end else if (!bus.sl) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          shift_q  <= shift_d;
          bitCnt_q <= CntW'(1);
          state_q  <= SHIFT;
        end
        SHIFT: begin
          shift_q <= shift_d;
          if (bitCnt_q == LastData) begin
`ifdef SIPO_PARITY_EN
            bitCnt_q <= bitCnt_q + 1'b1;
            state_q  <= PARITY;
`else
            bitCnt_q <= '0;
            state_q  <= SHIFT;
`endif
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        PARITY: begin
          bitCnt_q <= '0;
          state_q  <= SHIFT;
        end
        default: begin
          state_q  <= IDLE;
          shift_q  <= '0;
          bitCnt_q <= '0;
        end
      endcase
    end
  end

  assign busy    = (bitCnt_q != '0);
  assign bit_cnt = bitCnt_q;

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (wordDone),
    .data_i   (word),
    .ready_i  (bus.pout_ready),
    .clr_i    (overrun_clr),
`ifdef SIPO_PARITY_EN
    .err_i    (wordErr),
    .err_o    (parity_err),
`endif
    .data_o   (bus.pout),
    .valid_o  (bus.pout_valid),
    .overrun_o(overrun)
  );

endmodule
